cu_engine_s_axi_read_responder: RTL

AXI4 read-channel responder (slave end) that services burst read commands issued by a compute-unit engine's M_AXI read master.
- Backed by an internal word-addressed memory. The memory is preloaded through a simple write port.
- Returns AR-requested bursts on the R channel at one beat per cycle, honouring RREADY backpressure.
- Sits between an engine and on-chip scratch storage. It also serves as the bus-functional responder for engine-level simulation.

---
 rtl/cu_engine_s_axi_read_responder_pkg.sv | 30 +++
 rtl/cu_engine_s_axi_read_responder_ram.sv | 45 ++++
 rtl/cu_engine_s_axi_read_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cu_engine_s_axi_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cu_engine_s_axi_read_responder_pkg
// Description : Shared state encoding and AXI burst/response codes for the
//               engine S_AXI read responder.
// Revision    : 1.0 - initial release
// ============================================================================
package cu_engine_s_axi_read_responder_pkg;

    typedef enum logic [3:0] {
        CU_ENGINE_S_AXI_RESET = 4'b0001,
        CU_ENGINE_S_AXI_READY = 4'b0010,
        CU_ENGINE_S_AXI_BURST = 4'b0100,
        CU_ENGINE_S_AXI_DONE  = 4'b1000
    } cu_engine_s_axi_state;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Only FIXED and INCR are serviced; WRAP and the reserved code error out.
    function automatic logic burst_is_supported(input logic [1:0] burst);
        return (burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cu_engine_s_axi_read_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : cu_s_axi_ram_1r1w
// Description : One write port plus a registered, enabled read port with
//               read-before-write behaviour on address collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_s_axi_ram_1r1w #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage has no reset so preloaded contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Sampling r_mem before the write lands yields the old word on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/cu_engine_s_axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : cu_engine_s_axi_read_responder
// Description : AXI4 read-channel slave returning FIXED/INCR bursts from a
//               preloadable word memory, one beat per cycle under RREADY.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_engine_s_axi_read_responder
    import cu_engine_s_axi_read_responder_pkg::*;
#(
    parameter int S_AXI_ADDR_WIDTH = 16,
    parameter int S_AXI_DATA_WIDTH = 64,
    parameter int S_AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH        = 256,
    parameter int BURST_CNT_WIDTH  = 16
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [S_AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [1:0]                   s_axi_arburst,
    input  logic [S_AXI_ID_WIDTH-1:0]    s_axi_arid,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [S_AXI_DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic [S_AXI_ID_WIDTH-1:0]    s_axi_rid,
    input  logic                         mem_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
    input  logic [S_AXI_DATA_WIDTH-1:0]  mem_wr_data,
    output logic                         busy,
    output logic                         done_pulse,
    output logic [BURST_CNT_WIDTH-1:0]   burst_count
);

    localparam int c_idx_w    = $clog2(MEM_DEPTH);
    localparam int c_byte_off = $clog2(S_AXI_DATA_WIDTH / 8);

    cu_engine_s_axi_state r_state;
    cu_engine_s_axi_state w_state_next;

    logic [c_idx_w-1:0]          r_idx;
    logic [7:0]                  r_beats_left;
    logic [1:0]                  r_burst;
    logic [S_AXI_ID_WIDTH-1:0]   r_id;
    logic                        r_rvalid;
    logic                        r_slverr;
    logic [BURST_CNT_WIDTH-1:0]  r_burst_count;

    logic                        w_rd_en;
    logic [c_idx_w-1:0]          w_rd_addr;
    logic [c_idx_w-1:0]          w_ar_idx;
    logic [c_idx_w-1:0]          w_next_idx;
    logic                        w_beat_acc;
    logic [S_AXI_DATA_WIDTH-1:0] w_ram_q;
    logic                        w_unused_araddr;

    // Sub-word byte bits and bits above the memory range do not select a word.
    assign w_ar_idx        = s_axi_araddr[c_byte_off +: c_idx_w];
    assign w_unused_araddr = &{1'b0, s_axi_araddr};
    assign w_next_idx      = (r_burst == AXI_BURST_INCR) ? r_idx + 1'b1 : r_idx;
    assign w_beat_acc      = r_rvalid & s_axi_rready;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state <= CU_ENGINE_S_AXI_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_rd_addr    = r_idx;
        case (r_state)
            CU_ENGINE_S_AXI_RESET: begin
                w_state_next = CU_ENGINE_S_AXI_READY;
            end
            CU_ENGINE_S_AXI_READY: begin
                if (s_axi_arvalid) begin
                    w_state_next = CU_ENGINE_S_AXI_BURST;
                    w_rd_en      = 1'b1;
                    w_rd_addr    = w_ar_idx;
                end
            end
            CU_ENGINE_S_AXI_BURST: begin
                if (w_beat_acc) begin
                    if (r_beats_left != 8'd0) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_next_idx;
                    end else begin
                        w_state_next = CU_ENGINE_S_AXI_DONE;
                    end
                end
            end
            CU_ENGINE_S_AXI_DONE: begin
                w_state_next = CU_ENGINE_S_AXI_READY;
            end
            default: begin
                w_state_next = CU_ENGINE_S_AXI_RESET;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_idx         <= '0;
            r_beats_left  <= 8'd0;
            r_burst       <= AXI_BURST_FIXED;
            r_id          <= '0;
            r_rvalid      <= 1'b0;
            r_slverr      <= 1'b0;
            r_burst_count <= '0;
        end else begin
            if (r_state == CU_ENGINE_S_AXI_READY && s_axi_arvalid) begin
                r_idx        <= w_ar_idx;
                r_beats_left <= s_axi_arlen;
                r_burst      <= s_axi_arburst;
                r_id         <= s_axi_arid;
                r_slverr     <= !burst_is_supported(s_axi_arburst);
                r_rvalid     <= 1'b1;
            end
            if (r_state == CU_ENGINE_S_AXI_BURST && w_beat_acc) begin
                if (r_beats_left != 8'd0) begin
                    r_beats_left <= r_beats_left - 8'd1;
                    r_idx        <= w_next_idx;
                end else begin
                    r_rvalid <= 1'b0;
                end
            end
            if (r_state == CU_ENGINE_S_AXI_DONE) begin
                r_burst_count <= r_burst_count + 1'b1;
            end
        end
    end

    cu_s_axi_ram_1r1w #(
        .DATA_WIDTH (S_AXI_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .ADDR_WIDTH (c_idx_w)
    ) u_ram (
        .clk       (ap_clk),
        .rst       (areset),
        .i_wr_en   (mem_wr_en),
        .i_wr_addr (mem_wr_addr),
        .i_wr_data (mem_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign s_axi_arready = (r_state == CU_ENGINE_S_AXI_READY);
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_slverr ? '0 : w_ram_q;
    assign s_axi_rresp   = r_slverr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s_axi_rlast   = r_rvalid & (r_beats_left == 8'd0);
    assign s_axi_rid     = r_id;
    assign busy          = (r_state != CU_ENGINE_S_AXI_READY);
    assign done_pulse    = (r_state == CU_ENGINE_S_AXI_DONE);
    assign burst_count   = r_burst_count;

endmodule
`default_nettype wire
